// File: rtl/wisard_pkg.sv
// rtl/wisard_pkg.sv - shared WiSARD defaults, accumulator FSM encoding and score-width helper
package wisard_pkg;

    localparam int WISARD_N_CLASSES   = 10;
    localparam int WISARD_N_RAMS      = 27;
    localparam int WISARD_CLASS_WIDTH = 4;
    localparam int WISARD_SCORE_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_ARGMAX = 2'd1,
        ST_OUTPUT = 2'd2
    } accum_state_t;

    // Width of an unsaturated score+hit sum: one carry bit above the score itself.
    function automatic int sat_sum_width(input int score_width);
        return score_width + 1;
    endfunction

endpackage

// File: rtl/wisard_argmax.sv
// rtl/wisard_argmax.sv - sequential argmax, one class per cycle (best_score port only with WISARD_SCORE_OUT_EN)
module wisard_argmax
    import wisard_pkg::*;
#(
    parameter int N_CLASSES   = WISARD_N_CLASSES,
    parameter int CLASS_WIDTH = WISARD_CLASS_WIDTH,
    parameter int SCORE_WIDTH = WISARD_SCORE_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [N_CLASSES*SCORE_WIDTH-1:0] scores,
    output logic                             done,
    output logic [CLASS_WIDTH-1:0]           best_class
`ifdef WISARD_SCORE_OUT_EN
    ,
    output logic [SCORE_WIDTH-1:0]           best_score
`endif
);

    localparam logic [CLASS_WIDTH-1:0] LAST_CLASS = CLASS_WIDTH'(N_CLASSES - 1);

    logic                   busy;
    logic [CLASS_WIDTH-1:0] cnt;
    logic [SCORE_WIDTH-1:0] cur_score;
    logic [SCORE_WIDTH-1:0] best_score_q;

    // Select the score of the class currently under comparison
    always_comb begin
        cur_score = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            if (cnt == CLASS_WIDTH'(c)) begin
                cur_score = scores[c*SCORE_WIDTH +: SCORE_WIDTH];
            end
        end
    end

    // done coincides with the cycle that visits the last class
    assign done = busy && (cnt == LAST_CLASS);

    // Walk classes 0..N-1; class 0 seeds best, later classes replace it only when strictly greater
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            cnt          <= '0;
            best_class   <= '0;
            best_score_q <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if ((cnt == '0) || (cur_score > best_score_q)) begin
                best_class   <= cnt;
                best_score_q <= cur_score;
            end
            if (done) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef WISARD_SCORE_OUT_EN
    assign best_score = best_score_q;
`endif

endmodule

// File: rtl/wisard_class_accum.sv
// rtl/wisard_class_accum.sv - per-class WiSARD score accumulator and winner source (src_score with WISARD_SCORE_OUT_EN)
module wisard_class_accum
    import wisard_pkg::*;
#(
    parameter int N_CLASSES   = WISARD_N_CLASSES,
    parameter int N_RAMS      = WISARD_N_RAMS,
    parameter int CLASS_WIDTH = WISARD_CLASS_WIDTH,
    parameter int SCORE_WIDTH = WISARD_SCORE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sink_valid,
    input  logic                   sink_sop,
    input  logic                   sink_eop,
    input  logic [N_CLASSES-1:0]   sink_hits,
    output logic                   sink_ready,
    output logic                   src_valid,
    input  logic                   src_ready,
    output logic [CLASS_WIDTH-1:0] src_class
`ifdef WISARD_SCORE_OUT_EN
    ,
    output logic [SCORE_WIDTH-1:0] src_score
`endif
);

    localparam int SUM_W = sat_sum_width(SCORE_WIDTH);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

    accum_state_t                     state_q;
    accum_state_t                     state_d;
    logic [SCORE_WIDTH-1:0]           score_q   [N_CLASSES];
    logic [SCORE_WIDTH-1:0]           score_inc [N_CLASSES];
    logic [SUM_W-1:0]                 score_sum [N_CLASSES];
    logic [N_CLASSES*SCORE_WIDTH-1:0] score_vec;
    logic                             accept;
    logic                             out_fire;
    logic                             start_q;
    logic                             argmax_done;
    logic [CLASS_WIDTH-1:0]           best_class;

    assign accept   = sink_valid & sink_ready;
    assign out_fire = src_valid & src_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs: sink open only in ACCUM, source valid only in OUTPUT
    always_comb begin
        state_d    = state_q;
        sink_ready = 1'b0;
        src_valid  = 1'b0;
        unique case (state_q)
            ST_ACCUM: begin
                sink_ready = 1'b1;
                if (sink_valid && sink_eop) begin
                    state_d = ST_ARGMAX;
                end
            end
            ST_ARGMAX: begin
                if (argmax_done) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                src_valid = 1'b1;
                if (src_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Saturating increment candidates; the carry bit flags overflow past SCORE_MAX
    always_comb begin
        for (int c = 0; c < N_CLASSES; c++) begin
            score_sum[c] = {1'b0, score_q[c]} + SUM_W'(sink_hits[c]);
            score_inc[c] = score_sum[c][SUM_W-1] ? SCORE_MAX : score_sum[c][SCORE_WIDTH-1:0];
        end
    end

    // Score registers: sop restarts the sample, other beats accumulate, handoff clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                score_q[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                score_q[c] <= sink_sop ? SCORE_WIDTH'(sink_hits[c]) : score_inc[c];
            end
        end else if (out_fire) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                score_q[c] <= '0;
            end
        end
    end

    // Flatten the score array for the argmax walker
    always_comb begin
        score_vec = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            score_vec[c*SCORE_WIDTH +: SCORE_WIDTH] = score_q[c];
        end
    end

    // One-cycle start pulse after the eop beat, so the walker sees the final scores
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= accept & sink_eop;
        end
    end

    wisard_argmax #(
        .N_CLASSES   (N_CLASSES),
        .CLASS_WIDTH (CLASS_WIDTH),
        .SCORE_WIDTH (SCORE_WIDTH)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_q),
        .scores     (score_vec),
        .done       (argmax_done),
        .best_class (best_class)
`ifdef WISARD_SCORE_OUT_EN
        ,
        .best_score (src_score)
`endif
    );

    // The walker's registers are idle from OUTPUT until the next sample, so they hold the result
    assign src_class = best_class;

endmodule

// File: tb/tb_wisard_class_accum.sv
// tb/tb_wisard_class_accum.sv - scoreboard bench for wisard_class_accum (checks src_score with WISARD_SCORE_OUT_EN)
module tb_wisard_class_accum;

    localparam int NC = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sink_valid = 1'b0;
    logic          sink_sop = 1'b0;
    logic          sink_eop = 1'b0;
    logic [NC-1:0] sink_hits = '0;
    logic          src_ready = 1'b1;
    logic          sink_ready;
    logic          src_valid;
    logic [CW-1:0] src_class;
    logic          sink_ready4;
    logic          src_valid4;
    logic [CW-1:0] src_class4;
`ifdef WISARD_SCORE_OUT_EN
    logic [4:0]    src_score;
    logic [3:0]    src_score4;
`endif

    always #5 clk = ~clk;

    wisard_class_accum #(.N_CLASSES(NC), .N_RAMS(27), .CLASS_WIDTH(CW), .SCORE_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_hits(sink_hits), .sink_ready(sink_ready),
        .src_valid(src_valid), .src_ready(src_ready), .src_class(src_class)
`ifdef WISARD_SCORE_OUT_EN
        , .src_score(src_score)
`endif
    );

    wisard_class_accum #(.N_CLASSES(NC), .N_RAMS(27), .CLASS_WIDTH(CW), .SCORE_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_hits(sink_hits), .sink_ready(sink_ready4),
        .src_valid(src_valid4), .src_ready(1'b1), .src_class(src_class4)
`ifdef WISARD_SCORE_OUT_EN
        , .src_score(src_score4)
`endif
    );

    typedef struct {
        int cls;
        int sc5;
        int cls4;
        int sc4;
    } exp_t;

    exp_t          exp_q[$];
    logic [NC-1:0] s_hits[$];
    bit            s_sop[$];
    int            tests_run = 0;
    int            tests_failed = 0;
    int            cyc = 0;
    int            eop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model(input int width, output int cls, output int sc);
        int acc[NC];
        int mx;
        int h;
        mx = (1 << width) - 1;
        for (int c = 0; c < NC; c++) acc[c] = 0;
        for (int b = 0; b < s_hits.size(); b++) begin
            for (int c = 0; c < NC; c++) begin
                h = s_hits[b][c] ? 1 : 0;
                if (s_sop[b]) acc[c] = h;
                else acc[c] = (acc[c] + h > mx) ? mx : acc[c] + h;
            end
        end
        cls = 0;
        sc  = acc[0];
        for (int c = 1; c < NC; c++) begin
            if (acc[c] > sc) begin
                cls = c;
                sc  = acc[c];
            end
        end
    endfunction

    task automatic add_beat(input logic [NC-1:0] h, input bit sop);
        s_hits.push_back(h);
        s_sop.push_back(sop);
    endtask

    task automatic clear_sample();
        s_hits.delete();
        s_sop.delete();
    endtask

    // Drives the built sample (called at a negedge); expected result is pushed as the beats go out.
    task automatic send_sample();
        exp_t e;
        int   n;
        model(5, e.cls, e.sc5);
        model(4, e.cls4, e.sc4);
        exp_q.push_back(e);
        for (int b = 0; b < s_hits.size(); b++) begin
            sink_valid = 1'b1;
            sink_sop   = s_sop[b];
            sink_eop   = (b == s_hits.size() - 1);
            sink_hits  = s_hits[b];
            n = 0;
            while (!sink_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sink_ready_timeout beat=%0d waited=%0d required<200", b, n);
            end
            @(negedge clk);
        end
        eop_cyc    = cyc;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_hits  = '0;
    endtask

    task automatic wait_valid(output int lat, output bit to);
        int n;
        n = 0;
        while (!src_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        to  = !src_valid;
        lat = cyc - eop_cyc;
    endtask

    task automatic pop_exp(output exp_t e);
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty size=0 required>0");
            e = '{0, 0, 0, 0};
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (sink_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_sink_ready got=%b exp=1", sink_ready); end
        tests_run++;
        if (src_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_src_valid got=%b exp=0", src_valid); end
        tests_run++;
        if (src_class !== '0) begin tests_failed++; $display("FAIL reset_src_class got=%0d exp=0", src_class); end
        tests_run++;
        if (sink_ready4 !== 1'b1) begin tests_failed++; $display("FAIL reset_sink_ready4 got=%b exp=1", sink_ready4); end
`ifdef WISARD_SCORE_OUT_EN
        tests_run++;
        if (src_score !== '0) begin tests_failed++; $display("FAIL reset_src_score got=%0d exp=0", src_score); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t          e;
        int            lat;
        bit            to;
        logic [NC-1:0] h;
        clear_sample();
        for (int b = 0; b < 27; b++) begin
            h = (b % 2 == 0) ? '1 : '0;
            h[3] = 1'b1;
            add_beat(h, b == 0);
        end
        send_sample();
        tests_run++;
        if (sink_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_argmax_sink_ready got=%b exp=0", sink_ready); end
        wait_valid(lat, to);
        pop_exp(e);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL basic_timeout src_valid=%b exp=1", src_valid); end
        tests_run++;
        if (lat !== 11) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=11", lat); end
        tests_run++;
        if (src_class !== CW'(e.cls)) begin tests_failed++; $display("FAIL basic_class got=%0d exp=%0d", src_class, e.cls); end
`ifdef WISARD_SCORE_OUT_EN
        tests_run++;
        if (src_score !== 5'(e.sc5)) begin tests_failed++; $display("FAIL basic_score got=%0d exp=%0d", src_score, e.sc5); end
`endif
        @(negedge clk);
        tests_run++;
        if (src_valid !== 1'b0 || sink_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_handoff src_valid=%b sink_ready=%b exp=0/1", src_valid, sink_ready);
        end
    endtask

    task automatic test_tie();
        exp_t          e;
        int            lat;
        bit            to;
        logic [NC-1:0] h;
        clear_sample();
        for (int b = 0; b < 27; b++) begin
            h = (b < 10) ? '1 : '0;
            h[2] = (b < 20);
            h[7] = (b < 20);
            add_beat(h, b == 0);
        end
        send_sample();
        wait_valid(lat, to);
        pop_exp(e);
        tests_run++;
        if (to || src_class !== CW'(e.cls)) begin
            tests_failed++;
            $display("FAIL tie_class got=%0d exp=%0d timeout=%b", src_class, e.cls, to);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t          e;
        int            lat;
        bit            to;
        logic [NC-1:0] h;
        src_ready = 1'b0;
        clear_sample();
        for (int b = 0; b < 27; b++) begin
            h = '0;
            h[6] = 1'b1;
            add_beat(h, b == 0);
        end
        send_sample();
        wait_valid(lat, to);
        pop_exp(e);
        tests_run++;
        if (to || src_class !== CW'(e.cls)) begin
            tests_failed++;
            $display("FAIL bp_class got=%0d exp=%0d timeout=%b", src_class, e.cls, to);
        end
        clear_sample();
        for (int b = 0; b < 27; b++) begin
            h = '0;
            h[4] = (b < 15);
            h[6] = (b < 5);
            add_beat(h, 1'b0);
        end
        sink_valid = 1'b1;
        sink_hits  = s_hits[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (src_valid !== 1'b1 || src_class !== CW'(e.cls) || sink_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cyc=%0d src_valid=%b src_class=%0d sink_ready=%b exp=1/%0d/0",
                         i, src_valid, src_class, sink_ready, e.cls);
            end
        end
        src_ready = 1'b1;
        @(negedge clk);
        send_sample();
        wait_valid(lat, to);
        pop_exp(e);
        tests_run++;
        if (to || src_class !== CW'(e.cls)) begin
            tests_failed++;
            $display("FAIL bp_next_class got=%0d exp=%0d timeout=%b", src_class, e.cls, to);
        end
        @(negedge clk);
    endtask

    task automatic test_sop_restart();
        exp_t          e;
        int            lat;
        bit            to;
        logic [NC-1:0] h;
        clear_sample();
        for (int b = 0; b < 27; b++) begin
            h = '0;
            h[5] = (b < 17);
            h[8] = (b >= 10);
            h[1] = (b >= 10) && (b % 2 == 1);
            add_beat(h, (b == 0) || (b == 10));
        end
        send_sample();
        wait_valid(lat, to);
        pop_exp(e);
        tests_run++;
        if (to || src_class !== CW'(e.cls)) begin
            tests_failed++;
            $display("FAIL sop_restart_class got=%0d exp=%0d timeout=%b", src_class, e.cls, to);
        end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        exp_t e;
        int   lat;
        bit   to;
        clear_sample();
        for (int b = 0; b < 27; b++) add_beat('1, b == 0);
        send_sample();
        wait_valid(lat, to);
        pop_exp(e);
        tests_run++;
        if (to || src_class !== CW'(e.cls)) begin
            tests_failed++;
            $display("FAIL sat_class5 got=%0d exp=%0d timeout=%b", src_class, e.cls, to);
        end
        tests_run++;
        if (src_valid4 !== 1'b1 || src_class4 !== CW'(e.cls4)) begin
            tests_failed++;
            $display("FAIL sat_class4 valid=%b got=%0d exp=%0d", src_valid4, src_class4, e.cls4);
        end
`ifdef WISARD_SCORE_OUT_EN
        tests_run++;
        if (src_score4 !== 4'(e.sc4)) begin tests_failed++; $display("FAIL sat_score4 got=%0d exp=%0d", src_score4, e.sc4); end
        tests_run++;
        if (src_score !== 5'(e.sc5)) begin tests_failed++; $display("FAIL sat_score5 got=%0d exp=%0d", src_score, e.sc5); end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_argmax();
        exp_t          e;
        int            lat;
        bit            to;
        int            seen;
        logic [NC-1:0] h;
        clear_sample();
        for (int b = 0; b < 27; b++) begin
            h = '0;
            h[9] = 1'b1;
            add_beat(h, b == 0);
        end
        send_sample();
        void'(exp_q.pop_back());
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (sink_ready !== 1'b1 || src_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async sink_ready=%b src_valid=%b exp=1/0", sink_ready, src_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (src_valid) seen++;
        end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL rst_mid_no_valid got=%0d exp=0", seen); end
        clear_sample();
        for (int b = 0; b < 27; b++) begin
            h = '0;
            h[1] = (b < 20);
            h[9] = (b < 5);
            add_beat(h, 1'b0);
        end
        send_sample();
        wait_valid(lat, to);
        pop_exp(e);
        tests_run++;
        if (to || src_class !== CW'(e.cls)) begin
            tests_failed++;
            $display("FAIL rst_mid_next_class got=%0d exp=%0d timeout=%b", src_class, e.cls, to);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_sop_restart();
        test_saturate();
        test_reset_argmax();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
